branch_predictor_bht: RTL and testbench

Parametrised dynamic branch predictor replacing the static ID-stage predictor in the five-stage MIPS pipeline. It holds a table of saturating counters, optionally indexed gshare-style with a global history register (GHR). It predicts in ID and trains from the branch outcome resolved in MEM. The datapath carries `pred_idxD`, `ghrD` and `pred_takeD` down the pipeline and returns them at MEM for update and GHR repair.

---
 rtl/branch_predictor_bht_if.sv | 42 ++++
 rtl/branch_predictor_bht.sv | 116 +++++++++++
 tb/tb_branch_predictor_bht.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_bht_if.sv
// branch_predictor_bht_if
// Groups the ID-stage lookup signals and the MEM-stage training signals that
// pass between the pipeline datapath and the dynamic branch predictor.
//   master : datapath side (drives PC/branch/stall and the MEM-carried fields)
//   slave  : predictor side (returns prediction, index and GHR snapshot)
// Qualifiers: a lookup is accepted when branchD=1 and stallD=0. An update is
// accepted when update_enM=1 and stallM=0. No ready/backpressure exists; a
// held update under stallM is simply ignored until its unstalled cycle.
interface branch_predictor_bht_if #(
    parameter int INDEX_W = 6,
    parameter int GHR_W   = 0
);
    localparam int GW = (GHR_W > 0) ? GHR_W : 1;

    // ID stage
    logic [31:0]        pcD;
    logic               branchD;
    logic               stallD;
    logic               pred_takeD;
    logic [INDEX_W-1:0] pred_idxD;
    logic [GW-1:0]      ghrD;

    // MEM stage
    logic               update_enM;
    logic [INDEX_W-1:0] update_idxM;
    logic [GW-1:0]      ghrM;
    logic               pred_takeM;
    logic               actual_takeM;
    logic               stallM;

    modport master (
        output pcD, branchD, stallD,
        output update_enM, update_idxM, ghrM, pred_takeM, actual_takeM, stallM,
        input  pred_takeD, pred_idxD, ghrD
    );

    modport slave (
        input  pcD, branchD, stallD,
        input  update_enM, update_idxM, ghrM, pred_takeM, actual_takeM, stallM,
        output pred_takeD, pred_idxD, ghrD
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
// Table of 2^INDEX_W saturating counters, optionally indexed gshare-style by
// XOR with a global history register. Predicts combinationally in ID and
// trains from the outcome resolved in MEM; a misprediction repairs the GHR
// from the snapshot carried down the pipeline.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bp (slave)   : ID lookup and MEM update signals (see interface)
//   lookup_cnt   : number of accepted lookups (wraps modulo 2^32)
//   mispred_cnt  : number of accepted mispredicted updates (wraps)
module branch_predictor_bht #(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_predictor_bht_if.slave  bp,
    output logic [31:0]            lookup_cnt,
    output logic [31:0]            mispred_cnt
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int GW      = (GHR_W > 0) ? GHR_W : 1;
    // Weakly not-taken; evaluates to 0 for single-bit counters.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0]   cntTable [ENTRIES];
    logic [GW-1:0]      ghr;
    logic [GW-1:0]      ghrNext;
    logic [INDEX_W-1:0] ghrIdx;
    logic [INDEX_W-1:0] predIdx;
    logic               predTake;
    logic               lookupFire;
    logic               upd;
    logic               mis;
    logic [CNT_W-1:0]   cntOld;
    logic [CNT_W-1:0]   cntNew;
    logic               unusedPcBits;

    assign unusedPcBits = ^{bp.pcD[31:INDEX_W+2], bp.pcD[1:0]};

    // ---------------- lookup (ID) ----------------
    assign predIdx    = bp.pcD[INDEX_W+1:2] ^ ghrIdx;
    assign predTake   = bp.branchD & cntTable[predIdx][CNT_W-1];
    assign lookupFire = bp.branchD & ~bp.stallD;

    assign bp.pred_idxD  = predIdx;
    assign bp.pred_takeD = predTake;
    assign bp.ghrD       = ghr;

    // ---------------- training (MEM) ----------------
    assign upd    = bp.update_enM & ~bp.stallM;
    assign mis    = upd & (bp.pred_takeM ^ bp.actual_takeM);
    assign cntOld = cntTable[bp.update_idxM];

    always_comb begin
        cntNew = cntOld;
        if (bp.actual_takeM) begin
            if (cntOld != CNT_MAX) cntNew = cntOld + 1'b1;
        end else begin
            if (cntOld != '0) cntNew = cntOld - 1'b1;
        end
    end

    // No bypass: a same-cycle lookup of the written index sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) cntTable[i] <= CNT_INIT;
        end else if (upd) begin
            cntTable[bp.update_idxM] <= cntNew;
        end
    end

    // ---------------- global history ----------------
    // Repair from the MEM snapshot beats the ID speculative shift; the ID
    // instruction is flushed in that cycle so its shift must be dropped.
    generate
        if (GHR_W == 0) begin : g_noGhr
            logic unusedGhrM;
            assign unusedGhrM = ^bp.ghrM;
            assign ghrIdx     = '0;
            assign ghrNext    = '0;
        end else if (GHR_W == 1) begin : g_ghr1
            assign ghrIdx = INDEX_W'(ghr);
            always_comb begin
                ghrNext = ghr;
                if (mis)             ghrNext = bp.actual_takeM;
                else if (lookupFire) ghrNext = predTake;
            end
        end else begin : g_ghrN
            assign ghrIdx = INDEX_W'(ghr);
            always_comb begin
                ghrNext = ghr;
                if (mis)             ghrNext = {bp.ghrM[GHR_W-2:0], bp.actual_takeM};
                else if (lookupFire) ghrNext = {ghr[GHR_W-2:0], predTake};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ghr <= '0;
        else     ghr <= ghrNext;
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (lookupFire) lookup_cnt  <= lookup_cnt + 32'd1;
            if (mis)        mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht
// Directed bench for the predictor: dut0 is the PC-indexed configuration
// (INDEX_W=6, CNT_W=2, GHR_W=0), dut1 the gshare configuration (GHR_W=4).
// Inputs change on the falling edge; outputs are checked away from the
// rising edge.
module tb_branch_predictor_bht;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup0, mispred0, lookup1, mispred1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    branch_predictor_bht_if #(.INDEX_W(6), .GHR_W(0)) bp0 ();
    branch_predictor_bht_if #(.INDEX_W(6), .GHR_W(4)) bp1 ();

    branch_predictor_bht #(.INDEX_W(6), .CNT_W(2), .GHR_W(0)) dut0 (
        .clk(clk), .rst(rst), .bp(bp0), .lookup_cnt(lookup0), .mispred_cnt(mispred0)
    );
    branch_predictor_bht #(.INDEX_W(6), .CNT_W(2), .GHR_W(4)) dut1 (
        .clk(clk), .rst(rst), .bp(bp1), .lookup_cnt(lookup1), .mispred_cnt(mispred1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted-or-stalled update on dut0; called at a falling edge,
    // returns at the next falling edge with the update removed.
    task automatic upd0(input logic [5:0] idx, input logic act, input logic ptk,
                        input logic stl);
        bp0.update_enM   = 1'b1;
        bp0.update_idxM  = idx;
        bp0.actual_takeM = act;
        bp0.pred_takeM   = ptk;
        bp0.stallM       = stl;
        @(negedge clk);
        bp0.update_enM   = 1'b0;
        bp0.stallM       = 1'b0;
        #1;
    endtask

    task automatic upd1(input logic [5:0] idx, input logic act, input logic ptk,
                        input logic [3:0] gm);
        bp1.update_enM   = 1'b1;
        bp1.update_idxM  = idx;
        bp1.actual_takeM = act;
        bp1.pred_takeM   = ptk;
        bp1.ghrM         = gm;
        @(negedge clk);
        bp1.update_enM   = 1'b0;
        #1;
    endtask

    initial begin
        bp0.pcD = '0; bp0.branchD = 0; bp0.stallD = 0; bp0.update_enM = 0;
        bp0.update_idxM = '0; bp0.ghrM = '0; bp0.pred_takeM = 0;
        bp0.actual_takeM = 0; bp0.stallM = 0;
        bp1.pcD = '0; bp1.branchD = 0; bp1.stallD = 0; bp1.update_enM = 0;
        bp1.update_idxM = '0; bp1.ghrM = '0; bp1.pred_takeM = 0;
        bp1.actual_takeM = 0; bp1.stallM = 0;

        // ---- 1. reset ----
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bp0.pcD = 32'hBFC0_0014; bp0.branchD = 1'b1;
        #1;
        check("rst_pred_take", {31'd0, bp0.pred_takeD}, 32'd0);
        check("rst_pred_idx",  {26'd0, bp0.pred_idxD}, 32'd5);
        check("rst_ghrD",      {31'd0, bp0.ghrD}, 32'd0);
        check("rst_lookup",    lookup0, 32'd0);
        check("rst_mispred",   mispred0, 32'd0);
        check("rst_cnt5",      {30'd0, dut0.cntTable[5]}, 32'd1);
        @(negedge clk);
        bp0.branchD = 1'b0;
        #1;
        check("lookup_one", lookup0, 32'd1);

        // ---- 2. train taken on idx 5 (observe with stallD=1: no lookup count) ----
        bp0.pcD = 32'h0000_0014; bp0.branchD = 1'b1; bp0.stallD = 1'b1;
        upd0(6'd5, 1'b1, 1'b1, 1'b0);
        check("t1_cnt5", {30'd0, dut0.cntTable[5]}, 32'd2);
        check("t1_pred", {31'd0, bp0.pred_takeD}, 32'd1);
        upd0(6'd5, 1'b1, 1'b1, 1'b0);
        check("t2_cnt5", {30'd0, dut0.cntTable[5]}, 32'd3);
        upd0(6'd5, 1'b1, 1'b1, 1'b0);
        check("t3_sat_hi", {30'd0, dut0.cntTable[5]}, 32'd3);
        upd0(6'd5, 1'b1, 1'b1, 1'b0);
        check("t4_sat_hi", {30'd0, dut0.cntTable[5]}, 32'd3);
        upd0(6'd5, 1'b0, 1'b0, 1'b0);
        check("nt_cnt5", {30'd0, dut0.cntTable[5]}, 32'd2);
        check("nt_pred", {31'd0, bp0.pred_takeD}, 32'd1);
        check("stalled_no_lookup", lookup0, 32'd1);

        // ---- 3. saturate low and stall on idx 9 ----
        for (int i = 0; i < 4; i++) upd0(6'd9, 1'b0, 1'b0, 1'b0);
        check("sat_lo_cnt9", {30'd0, dut0.cntTable[9]}, 32'd0);
        check("addr_only_cnt5", {30'd0, dut0.cntTable[5]}, 32'd2);
        for (int i = 0; i < 5; i++) upd0(6'd9, 1'b1, 1'b1, 1'b1);
        check("stall_cnt9", {30'd0, dut0.cntTable[9]}, 32'd0);
        upd0(6'd9, 1'b1, 1'b1, 1'b0);
        check("unstall_cnt9", {30'd0, dut0.cntTable[9]}, 32'd1);

        // ---- 4. misprediction count ----
        check("mis_before", mispred0, 32'd0);
        upd0(6'd20, 1'b1, 1'b0, 1'b0);
        check("mis_one", mispred0, 32'd1);
        upd0(6'd20, 1'b1, 1'b1, 1'b0);
        check("mis_match", mispred0, 32'd1);
        upd0(6'd20, 1'b0, 1'b1, 1'b1);
        check("mis_stalled", mispred0, 32'd1);

        // ---- 6. same-cycle lookup/update collision on idx 5 (counter 2) ----
        bp0.update_enM = 1'b1; bp0.update_idxM = 6'd5;
        bp0.actual_takeM = 1'b0; bp0.pred_takeM = 1'b0;
        #1;
        check("coll_old_pred", {31'd0, bp0.pred_takeD}, 32'd1);
        @(negedge clk);
        bp0.update_enM = 1'b0;
        #1;
        check("coll_new_pred", {31'd0, bp0.pred_takeD}, 32'd0);

        // ---- 6. lookup counter wrap ----
        bp0.branchD = 1'b0; bp0.stallD = 1'b0;
        force dut0.lookup_cnt = 32'hFFFF_FFFF;
        #1;
        check("force_lookup", lookup0, 32'hFFFF_FFFF);
        release dut0.lookup_cnt;
        bp0.branchD = 1'b1;
        @(negedge clk);
        bp0.branchD = 1'b0;
        #1;
        check("lookup_wrap", lookup0, 32'd0);

        // ---- 5. gshare on dut1 ----
        upd1(6'd0, 1'b1, 1'b1, 4'd0);
        upd1(6'd0, 1'b1, 1'b1, 4'd0);
        check("gs_cnt0", {30'd0, dut1.cntTable[0]}, 32'd3);
        check("gs_ghr_quiet", {28'd0, bp1.ghrD}, 32'd0);
        bp1.pcD = 32'd0; bp1.branchD = 1'b1;
        #1;
        check("gs_pred", {31'd0, bp1.pred_takeD}, 32'd1);
        check("gs_idx0", {26'd0, bp1.pred_idxD}, 32'd0);
        @(negedge clk);
        #1;
        check("gs_ghr_spec", {28'd0, bp1.ghrD}, 32'd1);
        check("gs_idx1", {26'd0, bp1.pred_idxD}, 32'd1);
        // branchD still high: speculation (would give 0010) loses to repair
        upd1(6'd0, 1'b0, 1'b1, 4'b0000);
        check("gs_repair_wins", {28'd0, bp1.ghrD}, 32'd0);
        check("gs_mis", mispred1, 32'd1);
        check("gs_lookup", lookup1, 32'd2);
        bp1.branchD = 1'b0;
        upd1(6'd3, 1'b1, 1'b0, 4'b0101);
        check("gs_repair_shift", {28'd0, bp1.ghrD}, 32'hB);
        check("gs_idx_xor", {26'd0, bp1.pred_idxD}, 32'hB);

        // ---- reset mid-operation ----
        rst = 1'b1;
        #1;
        check("rerst_cnt5", {30'd0, dut0.cntTable[5]}, 32'd1);
        check("rerst_mispred", mispred0, 32'd0);
        check("rerst_ghr", {28'd0, bp1.ghrD}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
